tt_prim_pipe_buf: RTL and testbench



---
 rtl/tt_prim_pipe_buf.sv | 124 ++++++++++++
 tb/tb_tt_prim_pipe_buf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_prim_pipe_buf.sv
// Elastic valid/ready pipeline buffer with DEPTH register stages. The outputs are driven through tt_prim_buf cells.
// Optional synchronous flush port is enabled with `define TT_PRIM_PIPE_BUF_FLUSH_EN.

module tt_prim_buf #(
  parameter int HIGH_DRIVE = 0
) (
  input  logic a,
  output logic z
);
  // Both variants are logically identical; the split lets a cell swap key off the block name.
  generate
    if (HIGH_DRIVE != 0) begin : g_high
      assign z = a;
    end else begin : g_low
      assign z = a;
    end
  endgenerate
endmodule

module tt_prim_pipe_buf #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 2,
  parameter int HIGH_DRIVE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef TT_PRIM_PIPE_BUF_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                          flush_i;
  logic [DEPTH-1:0]              vld_q, vld_d, vld_src, rdy;
  logic [DEPTH-1:0][WIDTH-1:0]   dat_q, dat_d, dat_src;
  logic                          rdy_chain;
  logic [OCC_W-1:0]              occ_cnt;
  logic                          out_valid_raw;

`ifdef TT_PRIM_PIPE_BUF_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // A stage can take new data if it is empty or its successor is moving, so bubbles collapse.
  always_comb begin
    rdy       = '0;
    rdy_chain = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_chain = ~vld_q[k] | rdy_chain;
      rdy[k]    = rdy_chain;
    end
  end

  always_comb begin
    vld_src    = '0;
    dat_src    = '0;
    vld_src[0] = in_valid;
    dat_src[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      vld_src[k] = vld_q[k-1];
      dat_src[k] = dat_q[k-1];
    end

    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          vld_d[k] = vld_src[k];
          // Payload only moves with a valid word; a bubble leaves the old value in place.
          if (vld_src[k]) dat_d[k] = dat_src[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_cnt = occ_cnt + OCC_W'(vld_q[k]);
    end
  end

  assign occupancy     = occ_cnt;
  assign in_ready      = rdy[0] & ~rst & ~flush_i;
  assign out_valid_raw = vld_q[DEPTH-1] & ~flush_i;

  tt_prim_buf #(.HIGH_DRIVE(HIGH_DRIVE)) u_buf_vld (
    .a (out_valid_raw),
    .z (out_valid)
  );

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_out_buf
      tt_prim_buf #(.HIGH_DRIVE(HIGH_DRIVE)) u_buf_dat (
        .a (dat_q[DEPTH-1][i]),
        .z (out_data[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tt_prim_pipe_buf.sv
// Directed bench for tt_prim_pipe_buf: three instances (DEPTH 3, 4, 2) exercised in one linear sequence.
module tb_tt_prim_pipe_buf;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // DEPTH=3 instance
  logic [7:0] a_data, a_out_data;
  logic       a_valid, a_in_ready, a_out_valid, a_ready, a_flush;
  logic [1:0] a_occ;
  // DEPTH=4 instance
  logic [7:0] b_data, b_out_data;
  logic       b_valid, b_in_ready, b_out_valid, b_ready, b_flush;
  logic [2:0] b_occ;
  // DEPTH=2 instance
  logic [7:0] c_data, c_out_data;
  logic       c_valid, c_in_ready, c_out_valid, c_ready, c_flush;
  logic [1:0] c_occ;

  tt_prim_pipe_buf #(.WIDTH(8), .DEPTH(3), .HIGH_DRIVE(0)) u_a (
    .clk (clk), .rst (rst),
`ifdef TT_PRIM_PIPE_BUF_FLUSH_EN
    .flush (a_flush),
`endif
    .in_data (a_data), .in_valid (a_valid), .in_ready (a_in_ready),
    .out_data (a_out_data), .out_valid (a_out_valid), .out_ready (a_ready),
    .occupancy (a_occ)
  );

  tt_prim_pipe_buf #(.WIDTH(8), .DEPTH(4), .HIGH_DRIVE(1)) u_b (
    .clk (clk), .rst (rst),
`ifdef TT_PRIM_PIPE_BUF_FLUSH_EN
    .flush (b_flush),
`endif
    .in_data (b_data), .in_valid (b_valid), .in_ready (b_in_ready),
    .out_data (b_out_data), .out_valid (b_out_valid), .out_ready (b_ready),
    .occupancy (b_occ)
  );

  tt_prim_pipe_buf #(.WIDTH(8), .DEPTH(2), .HIGH_DRIVE(0)) u_c (
    .clk (clk), .rst (rst),
`ifdef TT_PRIM_PIPE_BUF_FLUSH_EN
    .flush (c_flush),
`endif
    .in_data (c_data), .in_valid (c_valid), .in_ready (c_in_ready),
    .out_data (c_out_data), .out_valid (c_out_valid), .out_ready (c_ready),
    .occupancy (c_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_word;
  logic [7:0] prev_data;
  logic       prev_stall;
  logic       pending;
  int         sent;
  int         rcvd;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    a_data = '0; a_valid = 0; a_ready = 0; a_flush = 0;
    b_data = '0; b_valid = 0; b_ready = 0; b_flush = 0;
    c_data = '0; c_valid = 0; c_ready = 0; c_flush = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_occ",       32'(a_occ),       32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(a_in_ready), 32'd1);

    // Two words held, then reset mid-stream
    step();
    a_valid = 1; a_data = 8'h11;
    step();
    a_data = 8'h22;
    step();
    a_valid = 0;
    #1;
    chk("hold_occ",       32'(a_occ),       32'd2);
    chk("hold_out_valid", 32'(a_out_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
    chk("midrst_occ",       32'(a_occ),       32'd0);
    chk("midrst_in_ready",  32'(a_in_ready),  32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrel_in_ready", 32'(a_in_ready), 32'd1);
    chk("midrel_occ",      32'(a_occ),      32'd0);
    step();

    // Latency 3 and back-to-back throughput, words 0x01..0x10
    for (int c = 0; c < 20; c++) begin
      a_ready = 1;
      a_valid = (c < 16);
      a_data  = 8'(c + 1);
      #1;
      if (c < 16) chk("lat_in_ready", 32'(a_in_ready), 32'd1);
      chk("lat_out_valid", 32'(a_out_valid), 32'((c >= 3) && (c <= 18)));
      if (c >= 3 && c <= 18) chk("lat_out_data", 32'(a_out_data), 32'(c - 2));
      step();
    end
    a_valid = 0;

    // Fill DEPTH=4 under backpressure
    for (int i = 0; i < 4; i++) begin
      b_valid = 1; b_data = 8'(8'hA0 + i);
      #1;
      chk("fill_in_ready", 32'(b_in_ready), 32'd1);
      step();
    end
    b_data = 8'hA4;
    #1;
    chk("full_in_ready",  32'(b_in_ready),  32'd0);
    chk("full_occ",       32'(b_occ),       32'd4);
    chk("full_out_valid", 32'(b_out_valid), 32'd1);
    chk("full_out_data",  32'(b_out_data),  32'hA0);
    step();
    chk("frozen_in_ready", 32'(b_in_ready), 32'd0);
    chk("frozen_out_data", 32'(b_out_data), 32'hA0);
    chk("frozen_occ",      32'(b_occ),      32'd4);
    for (int r = 0; r < 7; r++) begin
      b_ready = 1;
      b_valid = (r < 2);
      b_data  = 8'(8'hA4 + r);
      #1;
      if (r < 2) chk("drain_in_ready", 32'(b_in_ready), 32'd1);
      chk("drain_out_valid", 32'(b_out_valid), 32'(r < 6));
      if (r < 6) chk("drain_out_data", 32'(b_out_data), 32'(8'hA0 + r));
      step();
    end
    b_valid = 0;
    chk("drain_occ", 32'(b_occ), 32'd0);

    // DEPTH=2 full with simultaneous push and pop
    for (int i = 0; i < 2; i++) begin
      c_valid = 1; c_data = 8'(8'hB0 + i);
      #1;
      chk("c_fill_in_ready", 32'(c_in_ready), 32'd1);
      step();
    end
    c_data = 8'hB2;
    #1;
    chk("c_full_in_ready", 32'(c_in_ready), 32'd0);
    chk("c_full_occ",      32'(c_occ),      32'd2);
    for (int i = 0; i < 10; i++) begin
      c_ready = 1; c_data = 8'(8'hB2 + i);
      #1;
      chk("pp_in_ready",  32'(c_in_ready),  32'd1);
      chk("pp_occ",       32'(c_occ),       32'd2);
      chk("pp_out_valid", 32'(c_out_valid), 32'd1);
      chk("pp_out_data",  32'(c_out_data),  32'(8'hB0 + i));
      step();
    end
    c_valid = 0;
    for (int r = 0; r < 2; r++) begin
      #1;
      chk("pp_tail_data", 32'(c_out_data), 32'(8'hBA + r));
      step();
    end
    chk("pp_empty_valid", 32'(c_out_valid), 32'd0);
    chk("pp_empty_occ",   32'(c_occ),       32'd0);

    // Random stalls with scoreboard on DEPTH=3
    sent = 0; rcvd = 0; pending = 0; prev_stall = 0; prev_data = '0;
    a_valid = 0;
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      if (!pending) begin
        if (sent < 1000 && $urandom_range(1) == 1) begin
          a_valid = 1; a_data = 8'($urandom); pending = 1;
        end else begin
          a_valid = 0;
        end
      end
      a_ready = 1'($urandom_range(1));
      #1;
      if (prev_stall) chk("prod_stable", {23'd0, a_valid, a_data}, {23'd0, 1'b1, prev_data});
      chk("rand_occ", 32'(a_occ), 32'(q.size()));
      if (a_out_valid && a_ready) begin
        checks++;
        assert (q.size() != 0) else begin
          errors++;
          $error("FAIL rand_spurious: observed output 0x%0h expected no word", a_out_data);
        end
        if (q.size() != 0) begin
          exp_word = q.pop_front();
          chk("rand_data", 32'(a_out_data), 32'(exp_word));
        end
        rcvd++;
      end
      if (a_valid && a_in_ready) begin
        q.push_back(a_data);
        sent++;
        pending = 0;
      end
      prev_stall = a_valid & ~a_in_ready;
      prev_data  = a_data;
      step();
    end
    chk("rand_count", 32'(rcvd), 32'd1000);
    a_valid = 0; a_ready = 1;
    repeat (4) step();

`ifdef TT_PRIM_PIPE_BUF_FLUSH_EN
    // Flush a full DEPTH=3 pipe
    a_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_data = 8'(8'hC0 + i);
      #1;
      chk("fl_fill_in_ready", 32'(a_in_ready), 32'd1);
      step();
    end
    a_flush = 1; a_valid = 1; a_data = 8'hC3; a_ready = 1;
    #1;
    chk("fl_occ_before",  32'(a_occ),       32'd3);
    chk("fl_in_ready",    32'(a_in_ready),  32'd0);
    chk("fl_out_valid",   32'(a_out_valid), 32'd0);
    step();
    a_flush = 0; a_valid = 0;
    #1;
    chk("fl_occ_after",   32'(a_occ),       32'd0);
    chk("fl_valid_after", 32'(a_out_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      a_valid = (c == 0); a_data = 8'hC4;
      #1;
      if (c == 0) chk("fl_push_ready", 32'(a_in_ready), 32'd1);
      chk("fl_lat_valid", 32'(a_out_valid), 32'(c == 3));
      if (c == 3) chk("fl_lat_data", 32'(a_out_data), 32'hC4);
      step();
    end
    a_valid = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
